wbm_arbiter: RTL and testbench
==============================

Name: wbm_arbiter

Overview:
- Multi-master Wishbone arbiter.
- Shares the single master port of the board's slave-side address decoder between NUM_MASTERS requesters, for example the PPC EPB bridge and a debug/serial bridge.
- Grants one master at a time, forwards its single transfer downstream, and returns ack/err/data only to the granted master.
- Enforces a bus timeout of its own, independent of the downstream decoder.

Parameters:
- NUM_MASTERS, 2, number of upstream masters (1..8).
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority (lowest index wins).
- TIMEOUT, 1000, wb_clk_i cycles in WAIT before the arbiter aborts the transfer with an error.

Ports:
- wb_clk_i  in  1  Wishbone clock; the only clock in the block.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbm_cyc_i  in  NUM_MASTERS  per-master cycle.
- wbm_stb_i  in  NUM_MASTERS  per-master strobe.
- wbm_we_i  in  NUM_MASTERS  per-master write enable.
- wbm_sel_i  in  4*NUM_MASTERS  byte selects; master m uses [4m+3:4m].
- wbm_adr_i  in  32*NUM_MASTERS  addresses; master m uses [32m+31:32m].
- wbm_dat_i  in  32*NUM_MASTERS  write data, packed the same way as wbm_adr_i.
- wbm_dat_o  out  32  read data, registered, common to all masters.
- wbm_ack_o  out  NUM_MASTERS  one-hot ack pulse.
- wbm_err_o  out  NUM_MASTERS  one-hot error pulse.
- wbs_cyc_o  out  1  downstream cycle.
- wbs_stb_o  out  1  downstream strobe, equal to wbs_cyc_o.
- wbs_we_o  out  1  downstream write enable.
- wbs_sel_o  out  4  downstream byte selects.
- wbs_adr_o  out  32  downstream address.
- wbs_dat_o  out  32  downstream write data.
- wbs_dat_i  in  32  downstream read data.
- wbs_ack_i  in  1  downstream ack.
- wbs_err_i  in  1  downstream error.

Behaviour:
- Request definition: req[m] = wbm_cyc_i[m] & wbm_stb_i[m].
- Reset values (asynchronous on wb_rst_i):
  - state = IDLE; grant = 0; rr_ptr = 0; timeout counter = 0.
  - wbs_cyc_o/stb_o/we_o = 0; wbs_sel_o/adr_o/dat_o = 0.
  - wbm_dat_o = 0; wbm_ack_o = 0; wbm_err_o = 0.
- Reset mid-transfer: outputs drop immediately, regardless of the clock; no ack or err is issued.
- All outputs are registered.

State IDLE:
- If any req is set, select a winner:
  - Round-robin: first requesting index at or after rr_ptr, searching upward with modulo wrap.
  - Fixed priority: lowest requesting index.
- Next edge: grant = winner; latch the winner's we/sel/adr/dat into the wbs_* registers; wbs_cyc_o = wbs_stb_o = 1; go to WAIT.
- Latency from req to wbs_cyc_o is 1 cycle.

State WAIT:
- Timeout counter increments every cycle and is cleared on entry.
- Decisions are evaluated in this priority order:
  1. wbs_ack_i: wbm_dat_o <= wbs_dat_i; wbm_ack_o[grant] <= 1 for one cycle; cyc/stb <= 0; go to DONE.
  2. wbs_err_i: wbm_err_o[grant] <= 1 for one cycle; cyc/stb <= 0; go to DONE.
  3. wbm_cyc_i[grant] deasserted (master abort): cyc/stb <= 0; no ack or err; go to IDLE.
  4. Counter reaches TIMEOUT-1: wbm_err_o[grant] <= 1; cyc/stb <= 0; go to DONE.
- An ack arriving in the same cycle as timeout expiry wins; no err is issued.

State DONE (1 cycle):
- Ignores all requests, because the granted master still holds stb in the cycle it sees ack.
- Ack/err pulses clear.
- In round-robin mode, rr_ptr <= (grant+1) mod NUM_MASTERS.
- Go to IDLE.

General rules:
- wbm_dat_o holds its value until the next read ack.
- wbm_ack_o and wbm_err_o are never both set, and never set for a non-granted master.
- Maximum issue rate is one transfer per 3 cycles plus slave latency.
- Requests from non-granted masters are held off with no ack; they keep stb asserted until served.
- NUM_MASTERS = 1: the pointer is always 0 and the block acts as a registered pass-through.

Test Plan:
- Single read: master 0 reads 0x0000_1004; slave acks 2 cycles after wbs_stb_o with 0xDEAD_BEEF -> wbs_adr_o = 0x0000_1004 one cycle after req; wbm_ack_o = 2'b01 for exactly 1 cycle; wbm_dat_o = 0xDEAD_BEEF.
- Round-robin fairness: masters 0 and 1 request continuously, slave acks immediately -> grants alternate 0,1,0,1; no master is granted twice in a row while the other waits; each ack pulse goes only to its master.
- Fixed priority (ARB_MODE=1): both masters request continuously -> master 0 served every transfer; master 1 served only after master 0 drops cyc.
- Timeout (TIMEOUT=16): slave never acks -> wbs_cyc_o falls and wbm_err_o[grant] pulses exactly 16 cycles after WAIT entry; the arbiter is IDLE 2 cycles later. Ack and timeout in the same cycle -> ack only, no err.
- Slave error and master abort: wbs_err_i during master 1 write -> wbm_err_o = 2'b10 for one cycle. Master 0 drops cyc in WAIT -> wbs_cyc_o low next cycle, no ack/err, next request granted normally.
- Async reset: assert wb_rst_i mid-WAIT between clock edges -> wbs_cyc_o = 0 immediately; after release, first grant goes to master 0 with both requesting.

Source files
------------

// File: rtl/wbm_arbiter.sv
// -----------------------------------------------------------------------------
// wbm_arbiter
//
// Multi-master Wishbone arbiter. Several upstream masters (for example the PPC
// EPB bridge and a debug/serial bridge) share the one master port of the
// board's slave-side address decoder. One master is granted at a time. Its
// single transfer is forwarded downstream, and ack/err/read data go back only
// to that master. The arbiter also runs its own bus timeout, independent of
// the downstream decoder, so a hung slave cannot lock up the upstream masters.
//
// Parameters
//   NUM_MASTERS  number of upstream masters (1..8)
//   ARB_MODE     0 = round-robin, 1 = fixed priority (lowest index wins)
//   TIMEOUT      wb_clk_i cycles spent waiting before the transfer is aborted
//                with an error
//
// Ports
//   wb_clk_i, wb_rst_i          clock and asynchronous active-high reset
//   wbm_cyc_i/stb_i/we_i        per-master cycle, strobe and write enable
//   wbm_sel_i                   byte selects, master m on [4m+3:4m]
//   wbm_adr_i, wbm_dat_i        address and write data, master m on [32m+31:32m]
//   wbm_dat_o                   registered read data, shared by all masters
//   wbm_ack_o, wbm_err_o        one-hot ack / error pulses to the granted master
//   wbs_cyc_o/stb_o/we_o        downstream cycle, strobe (same as cyc), write
//   wbs_sel_o/adr_o/dat_o       downstream byte selects, address, write data
//   wbs_dat_i/ack_i/err_i       downstream read data, ack and error
//
// Every output is a register.
// -----------------------------------------------------------------------------
module wbm_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT     = 1000
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,

  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [4*NUM_MASTERS-1:0]    wbm_sel_i,
  input  logic [32*NUM_MASTERS-1:0]   wbm_adr_i,
  input  logic [32*NUM_MASTERS-1:0]   wbm_dat_i,
  output logic [31:0]                 wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,

  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic                        wbs_we_o,
  output logic [3:0]                  wbs_sel_o,
  output logic [31:0]                 wbs_adr_o,
  output logic [31:0]                 wbs_dat_o,
  input  logic [31:0]                 wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i
);

  // Index width is kept at least one bit, so the single-master build still
  // has legal vectors. In that build the pointer simply never leaves zero.
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  // The counter only needs to reach TIMEOUT-1, because that is the value at
  // which the abort fires.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        grant;
  logic [IDX_W-1:0]        rr_ptr;
  logic [CNT_W-1:0]        tmo_cnt;

  logic [NUM_MASTERS-1:0]  req;
  logic                    any_req;
  logic [IDX_W-1:0]        winner;
  logic [IDX_W-1:0]        next_ptr;
  logic [NUM_MASTERS-1:0]  grant_onehot;
  logic                    found;
  int                      scan_idx;
  int                      next_int;

  // A master is requesting only while both its cycle and its strobe are high.
  assign req     = wbm_cyc_i & wbm_stb_i;
  assign any_req = |req;

  // Winner selection.
  // In fixed-priority mode, the scan runs downward so the lowest requesting
  // index is written last and wins.
  // In round-robin mode, the scan starts at rr_ptr and wraps once around the
  // ring. It stops at the first requester it finds.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req[i]) begin
          winner = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= NUM_MASTERS) begin
          scan_idx = scan_idx - NUM_MASTERS;
        end
        if (!found && req[scan_idx]) begin
          found  = 1'b1;
          winner = IDX_W'(scan_idx);
        end
      end
    end
  end

  // Pointer value for after the current transfer: the master just past the
  // one granted, wrapping modulo NUM_MASTERS. This also works when
  // NUM_MASTERS is not a power of two.
  always_comb begin
    next_int = int'(grant) + 1;
    if (next_int >= NUM_MASTERS) begin
      next_int = 0;
    end
    next_ptr = IDX_W'(next_int);
  end

  // One-hot form of the grant, used to steer the ack and err pulses.
  always_comb begin
    grant_onehot        = '0;
    grant_onehot[grant] = 1'b1;
  end

  // Main controller, one transfer at a time through IDLE -> WAIT -> DONE.
  //
  // The ack and err pulses are cleared by default on every edge. They are
  // set only on the edge that leaves WAIT, so each pulse lasts exactly one
  // cycle.
  //
  // Inside WAIT the decisions are ordered ack, err, master abort, timeout.
  // A slave ack that lands on the same edge as the timeout therefore still
  // completes normally.
  //
  // DONE exists because the granted master is still holding stb during the
  // cycle it sees ack. Arbitrating in that cycle would re-grant a transfer
  // that has already finished.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      tmo_cnt   <= '0;
      wbs_cyc_o <= 1'b0;
      wbs_stb_o <= 1'b0;
      wbs_we_o  <= 1'b0;
      wbs_sel_o <= '0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbm_dat_o <= '0;
      wbm_ack_o <= '0;
      wbm_err_o <= '0;
    end else begin
      wbm_ack_o <= '0;
      wbm_err_o <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant     <= winner;
            wbs_we_o  <= wbm_we_i[winner];
            wbs_sel_o <= wbm_sel_i[4*winner +: 4];
            wbs_adr_o <= wbm_adr_i[32*winner +: 32];
            wbs_dat_o <= wbm_dat_i[32*winner +: 32];
            wbs_cyc_o <= 1'b1;
            wbs_stb_o <= 1'b1;
            tmo_cnt   <= '0;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (wbs_ack_i) begin
            wbm_dat_o <= wbs_dat_i;
            wbm_ack_o <= grant_onehot;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            state     <= ST_DONE;
          end else if (wbs_err_i) begin
            wbm_err_o <= grant_onehot;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            state     <= ST_DONE;
          end else if (!wbm_cyc_i[grant]) begin
            // The master walked away, so it gets no response. Go straight
            // back to IDLE; the pointer is left where it was.
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            state     <= ST_IDLE;
          end else if (tmo_cnt == CNT_LAST) begin
            wbm_err_o <= grant_onehot;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (ARB_MODE == 0) begin
            rr_ptr <= next_ptr;
          end
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wbm_arbiter
//
// Directed bench for wbm_arbiter. Two instances are used:
//   dut_rr  round-robin,    TIMEOUT = 16, inputs prefixed a_
//   dut_fp  fixed priority, TIMEOUT = 16, inputs prefixed b_
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// at the same point, so each sample shows the effect of the edge just taken.
// -----------------------------------------------------------------------------
module tb_wbm_arbiter;

  logic        clk;
  logic        rst;

  logic [1:0]  a_cyc, a_stb, a_we;
  logic [7:0]  a_sel;
  logic [63:0] a_adr, a_dat;
  logic [31:0] a_mdat;
  logic [1:0]  a_mack, a_merr;
  logic        a_scyc, a_sstb, a_swe;
  logic [3:0]  a_ssel;
  logic [31:0] a_sadr, a_sdato, a_sdat;
  logic        a_sack, a_serr;

  logic [1:0]  b_cyc, b_stb, b_we;
  logic [7:0]  b_sel;
  logic [63:0] b_adr, b_dat;
  logic [31:0] b_mdat;
  logic [1:0]  b_mack, b_merr;
  logic        b_scyc, b_sstb, b_swe;
  logic [3:0]  b_ssel;
  logic [31:0] b_sadr, b_sdato, b_sdat;
  logic        b_sack, b_serr;

  int checks;
  int failures;

  wbm_arbiter #(.NUM_MASTERS(2), .ARB_MODE(0), .TIMEOUT(16)) dut_rr (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_cyc_i(a_cyc), .wbm_stb_i(a_stb), .wbm_we_i(a_we),
    .wbm_sel_i(a_sel), .wbm_adr_i(a_adr), .wbm_dat_i(a_dat),
    .wbm_dat_o(a_mdat), .wbm_ack_o(a_mack), .wbm_err_o(a_merr),
    .wbs_cyc_o(a_scyc), .wbs_stb_o(a_sstb), .wbs_we_o(a_swe),
    .wbs_sel_o(a_ssel), .wbs_adr_o(a_sadr), .wbs_dat_o(a_sdato),
    .wbs_dat_i(a_sdat), .wbs_ack_i(a_sack), .wbs_err_i(a_serr)
  );

  wbm_arbiter #(.NUM_MASTERS(2), .ARB_MODE(1), .TIMEOUT(16)) dut_fp (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_cyc_i(b_cyc), .wbm_stb_i(b_stb), .wbm_we_i(b_we),
    .wbm_sel_i(b_sel), .wbm_adr_i(b_adr), .wbm_dat_i(b_dat),
    .wbm_dat_o(b_mdat), .wbm_ack_o(b_mack), .wbm_err_o(b_merr),
    .wbs_cyc_o(b_scyc), .wbs_stb_o(b_sstb), .wbs_we_o(b_swe),
    .wbs_sel_o(b_ssel), .wbs_adr_o(b_sadr), .wbs_dat_o(b_sdato),
    .wbs_dat_i(b_sdat), .wbs_ack_i(b_sack), .wbs_err_i(b_serr)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Drive one master of the round-robin instance.
  task automatic applyStimulus(input int m, input logic rq, input logic we,
                               input logic [3:0] sel, input logic [31:0] adr,
                               input logic [31:0] dat);
    a_cyc[m]          = rq;
    a_stb[m]          = rq;
    a_we[m]           = we;
    a_sel[4*m +: 4]   = sel;
    a_adr[32*m +: 32] = adr;
    a_dat[32*m +: 32] = dat;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    a_cyc = '0; a_stb = '0; a_we = '0; a_sel = '0; a_adr = '0; a_dat = '0;
    a_sdat = '0; a_sack = 1'b0; a_serr = 1'b0;
    b_cyc = '0; b_stb = '0; b_we = '0; b_sel = '0; b_adr = '0; b_dat = '0;
    b_sdat = '0; b_sack = 1'b0; b_serr = 1'b0;

    // ---- Reset state ----
    repeat (2) stepClock();
    checkOutput("rst_scyc", a_scyc, 0);
    checkOutput("rst_sadr", a_sadr, 0);
    checkOutput("rst_mack", a_mack, 0);
    checkOutput("rst_merr", a_merr, 0);
    checkOutput("rst_mdat", a_mdat, 0);
    checkOutput("rst_fp_scyc", b_scyc, 0);
    rst = 1'b0;
    stepClock();

    // ---- Single read: master 0, slave acks two cycles after stb ----
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h0000_1004, 32'h0);
    stepClock();
    checkOutput("rd_scyc", a_scyc, 1);
    checkOutput("rd_sstb", a_sstb, 1);
    checkOutput("rd_sadr", a_sadr, 32'h0000_1004);
    checkOutput("rd_swe", a_swe, 0);
    stepClock();
    checkOutput("rd_noack_early", a_mack, 0);
    a_sack = 1'b1;
    a_sdat = 32'hDEAD_BEEF;
    stepClock();
    checkOutput("rd_mack", a_mack, 2'b01);
    checkOutput("rd_mdat", a_mdat, 32'hDEAD_BEEF);
    checkOutput("rd_scyc_low", a_scyc, 0);
    a_sack = 1'b0;
    a_sdat = 32'h0;
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    stepClock();
    checkOutput("rd_mack_1cyc", a_mack, 0);
    checkOutput("rd_mdat_hold", a_mdat, 32'hDEAD_BEEF);

    // ---- Round-robin fairness: pointer is 1 now, so grants go 1,0,1,0 ----
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
    a_sack = 1'b1;
    a_sdat = 32'h5555_0000;
    for (int k = 0; k < 4; k++) begin
      stepClock();
      checkOutput($sformatf("rr%0d_sadr", k), a_sadr,
                  (k % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100);
      stepClock();
      checkOutput($sformatf("rr%0d_mack", k), a_mack,
                  (k % 2 == 0) ? 2'b10 : 2'b01);
      checkOutput($sformatf("rr%0d_merr", k), a_merr, 0);
      stepClock();
      checkOutput($sformatf("rr%0d_done", k), a_mack, 0);
    end
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    a_sack = 1'b0;

    // ---- Timeout: master 1, slave silent, err 16 cycles after WAIT entry ----
    applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
    stepClock();
    checkOutput("to_scyc", a_scyc, 1);
    repeat (15) stepClock();
    checkOutput("to_scyc_w15", a_scyc, 1);
    checkOutput("to_merr_w15", a_merr, 0);
    stepClock();
    checkOutput("to_scyc_w16", a_scyc, 0);
    checkOutput("to_merr_w16", a_merr, 2'b10);
    checkOutput("to_mack_w16", a_mack, 0);
    applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    stepClock();
    checkOutput("to_merr_1cyc", a_merr, 0);
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h0000_0310, 32'h0);
    stepClock();
    checkOutput("to_idle_regrant", a_sadr, 32'h0000_0310);

    // ---- Ack on the same edge as timeout expiry: ack only ----
    repeat (15) stepClock();
    a_sack = 1'b1;
    a_sdat = 32'hA5A5_0001;
    stepClock();
    checkOutput("tack_mack", a_mack, 2'b01);
    checkOutput("tack_merr", a_merr, 0);
    checkOutput("tack_mdat", a_mdat, 32'hA5A5_0001);
    a_sack = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    stepClock();

    // ---- Slave error during a master 1 write ----
    applyStimulus(1, 1'b1, 1'b1, 4'h3, 32'h0000_0400, 32'h1234_5678);
    stepClock();
    checkOutput("serr_swe", a_swe, 1);
    checkOutput("serr_ssel", a_ssel, 4'h3);
    checkOutput("serr_sdato", a_sdato, 32'h1234_5678);
    a_serr = 1'b1;
    stepClock();
    checkOutput("serr_merr", a_merr, 2'b10);
    checkOutput("serr_mack", a_mack, 0);
    checkOutput("serr_scyc", a_scyc, 0);
    a_serr = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    stepClock();
    checkOutput("serr_merr_1cyc", a_merr, 0);
    checkOutput("serr_mdat_hold", a_mdat, 32'hA5A5_0001);

    // ---- Master abort: master 0 drops cyc while the arbiter waits ----
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h0000_0500, 32'h0);
    stepClock();
    checkOutput("ab_scyc", a_scyc, 1);
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    stepClock();
    checkOutput("ab_scyc_low", a_scyc, 0);
    checkOutput("ab_mack", a_mack, 0);
    checkOutput("ab_merr", a_merr, 0);
    applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'h0);
    stepClock();
    checkOutput("ab_next_scyc", a_scyc, 1);
    checkOutput("ab_next_sadr", a_sadr, 32'h0000_0600);
    a_sack = 1'b1;
    stepClock();
    checkOutput("ab_next_mack", a_mack, 2'b10);
    a_sack = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    stepClock();

    // One transfer by master 0 moves the pointer to 1.
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h0000_0700, 32'h0);
    stepClock();
    a_sack = 1'b1;
    stepClock();
    checkOutput("pre_rst_mack", a_mack, 2'b01);
    a_sack = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    stepClock();

    // ---- Async reset mid-WAIT, then the first grant after it goes to 0 ----
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h0000_0800, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h0000_0900, 32'h0);
    stepClock();
    checkOutput("ar_grant_before", a_sadr, 32'h0000_0900);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("ar_scyc_now", a_scyc, 0);
    checkOutput("ar_sstb_now", a_sstb, 0);
    checkOutput("ar_sadr_now", a_sadr, 0);
    stepClock();
    checkOutput("ar_mack", a_mack, 0);
    checkOutput("ar_merr", a_merr, 0);
    rst = 1'b0;
    stepClock();
    checkOutput("ar_first_scyc", a_scyc, 1);
    checkOutput("ar_first_sadr", a_sadr, 32'h0000_0800);
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) stepClock();

    // ---- Fixed priority: master 0 always wins until it drops cyc ----
    b_cyc  = 2'b11;
    b_stb  = 2'b11;
    b_sel  = 8'hFF;
    b_adr  = {32'h0000_B100, 32'h0000_B000};
    b_sack = 1'b1;
    b_sdat = 32'h7777_0000;
    for (int k = 0; k < 3; k++) begin
      stepClock();
      checkOutput($sformatf("fp%0d_sadr", k), b_sadr, 32'h0000_B000);
      stepClock();
      checkOutput($sformatf("fp%0d_mack", k), b_mack, 2'b01);
      stepClock();
    end
    b_cyc[0] = 1'b0;
    b_stb[0] = 1'b0;
    stepClock();
    checkOutput("fp_m1_sadr", b_sadr, 32'h0000_B100);
    stepClock();
    checkOutput("fp_m1_mack", b_mack, 2'b10);
    checkOutput("fp_m1_mdat", b_mdat, 32'h7777_0000);
    b_cyc  = 2'b00;
    b_stb  = 2'b00;
    b_sack = 1'b0;
    repeat (2) stepClock();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
